// File: rtl/pc_sequencer.sv
// Next-PC controller for the fetch front end: sequential stepping, ROB/branch
// redirects with epoch tagging and buffer flush, and debug halt/resume.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned EPOCH_W  = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_adv,
  input  logic               rob_flush_valid,
  input  logic [31:0]        rob_flush_pc,
  input  logic               br_redirect_valid,
  input  logic [31:0]        br_redirect_pc,
  input  logic               halt_req,
  input  logic               resume,
  output logic [31:0]        pc_out,
  output logic               pc_valid,
  output logic [EPOCH_W-1:0] epoch,
  output logic               flush_out,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    REDIR  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic               flush_q, flush_d;
  logic               valid_q, valid_d;

  logic               redirect;
  logic [31:0]        redirect_target;

  // ROB flushes outrank branch mispredicts when both arrive together.
  assign redirect        = rob_flush_valid || br_redirect_valid;
  assign redirect_target = rob_flush_valid ? rob_flush_pc : br_redirect_pc;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    epoch_d = epoch_q;
    flush_d = 1'b0;

    if (state_q == BOOT) begin
      state_d = RUN;
    end else if (redirect) begin
      pc_d    = {redirect_target[31:2], 2'b00};
      epoch_d = epoch_q + 1'b1;
      flush_d = 1'b1;
      state_d = (state_q == HALTED) ? HALTED : REDIR;
    end else begin
      unique case (state_q)
        RUN: begin
          if (halt_req)       state_d = HALTED;
          else if (fetch_adv) pc_d    = pc_q + 32'd4;
        end
        REDIR:  state_d = RUN;
        HALTED: if (resume) state_d = RUN;
        default: state_d = state_q;
      endcase
    end

    // Only RUN presents a fetchable PC; registering it keeps pc_valid glitch-free.
    valid_d = (state_d == RUN);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      epoch_q <= '0;
      flush_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epoch_q <= epoch_d;
      flush_q <= flush_d;
      valid_q <= valid_d;
    end
  end

  assign pc_out    = pc_q;
  assign pc_valid  = valid_q;
  assign epoch     = epoch_q;
  assign flush_out = flush_q;
  assign state     = state_q;

endmodule
